// File: rtl/wb_result_stage_if.sv
// Interface carrying the M-stage inputs and W-stage outputs of the writeback result stage.
// The master drives M-stage inputs and stall/flush; the slave is the stage itself.
interface wb_result_stage_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned CNT_WIDTH  = 32
);
    localparam int unsigned SEL_WIDTH = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1;

    logic                          StallW;
    logic                          FlushW;
    logic                          ValidM;
    logic                          RegWriteM;
    logic [4:0]                    RdM;
    logic [SEL_WIDTH-1:0]          ResultSrcM;
    logic [NUM_SRC*DATA_WIDTH-1:0] SrcDataM;
    logic [2:0]                    LoadFunct3M;
    logic [1:0]                    ByteOffsetM;

    logic                          ValidW;
    logic                          RegWriteW;
    logic [4:0]                    RdW;
    logic [DATA_WIDTH-1:0]         ResultW;
    logic                          MisalignW;
    logic [CNT_WIDTH-1:0]          InstRetW;

    modport master (
        output StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, SrcDataM,
               LoadFunct3M, ByteOffsetM,
        input  ValidW, RegWriteW, RdW, ResultW, MisalignW, InstRetW
    );

    modport slave (
        input  StallW, FlushW, ValidM, RegWriteM, RdM, ResultSrcM, SrcDataM,
               LoadFunct3M, ByteOffsetM,
        output ValidW, RegWriteW, RdW, ResultW, MisalignW, InstRetW
    );
endinterface

// File: rtl/wb_result_stage.sv
// Writeback result stage: selects the result source, applies load extension and
// alignment checks, and registers the W-stage state plus a retired-instruction counter.
module wb_result_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned LOAD_IDX   = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input logic              clk,
    input logic              rst_n,
    wb_result_stage_if.slave bus
);
    localparam int unsigned SEL_WIDTH = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1;

    logic [DATA_WIDTH-1:0] src_word;
    logic [DATA_WIDTH-1:0] ext_word;
    logic [31:0]           lo_word;
    logic [7:0]            byte_v;
    logic [15:0]           half_v;
    logic                  is_load;
    logic                  misalign;

    logic                  valid_q;
    logic                  regwrite_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] result_q;
    logic                  misalign_q;
    logic [CNT_WIDTH-1:0]  instret_q;

    // Out-of-range selects fall through the loop and leave the word at zero.
    always_comb begin
        src_word = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (bus.ResultSrcM == SEL_WIDTH'(i)) begin
                src_word = bus.SrcDataM[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        is_load  = (bus.ResultSrcM == SEL_WIDTH'(LOAD_IDX));
        lo_word  = src_word[31:0];
        byte_v   = lo_word[{bus.ByteOffsetM, 3'b000} +: 8];
        half_v   = lo_word[{bus.ByteOffsetM[1], 4'b0000} +: 16];
        ext_word = src_word;
        misalign = 1'b0;
        if (is_load) begin
            case (bus.LoadFunct3M)
                3'b000: ext_word = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
                3'b001: begin
                    ext_word = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
                    misalign = bus.ByteOffsetM[0];
                end
                3'b010: begin
                    ext_word = {{(DATA_WIDTH-32){lo_word[31]}}, lo_word};
                    misalign = (bus.ByteOffsetM != 2'b00);
                end
                3'b100: ext_word = {{(DATA_WIDTH-8){1'b0}}, byte_v};
                3'b101: begin
                    ext_word = {{(DATA_WIDTH-16){1'b0}}, half_v};
                    misalign = bus.ByteOffsetM[0];
                end
                default: ext_word = src_word;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            result_q   <= '0;
            misalign_q <= 1'b0;
            instret_q  <= '0;
        end else if (bus.FlushW || (!bus.StallW && !bus.ValidM)) begin
            // Bubble: flush wins over stall; rd/result are don't-care and simply held.
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end else if (!bus.StallW) begin
            valid_q    <= 1'b1;
            regwrite_q <= bus.RegWriteM && (bus.RdM != 5'd0) && !misalign;
            rd_q       <= bus.RdM;
            result_q   <= misalign ? '0 : ext_word;
            misalign_q <= misalign;
            instret_q  <= instret_q + CNT_WIDTH'(1);
        end
    end

    assign bus.ValidW    = valid_q;
    assign bus.RegWriteW = regwrite_q;
    assign bus.RdW       = rd_q;
    assign bus.ResultW   = result_q;
    assign bus.MisalignW = misalign_q;
    assign bus.InstRetW  = instret_q;
endmodule

// File: tb/tb_wb_result_stage.sv
// Directed bench for wb_result_stage: default instance plus a NUM_SRC=3, CNT_WIDTH=4 instance.
module tb_wb_result_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    wb_result_stage_if #(.DATA_WIDTH(32), .NUM_SRC(4), .CNT_WIDTH(32)) bus0 ();
    wb_result_stage_if #(.DATA_WIDTH(32), .NUM_SRC(3), .CNT_WIDTH(4))  bus1 ();

    wb_result_stage #(.DATA_WIDTH(32), .NUM_SRC(4), .LOAD_IDX(1), .CNT_WIDTH(32)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    wb_result_stage #(.DATA_WIDTH(32), .NUM_SRC(3), .LOAD_IDX(1), .CNT_WIDTH(4)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic valid, input logic regw, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] off);
        bus0.ValidM      = valid;
        bus0.RegWriteM   = regw;
        bus0.RdM         = rd;
        bus0.ResultSrcM  = sel;
        bus0.LoadFunct3M = f3;
        bus0.ByteOffsetM = off;
    endtask

    task automatic load0(input string tag, input logic [2:0] f3, input logic [1:0] off,
                         input logic [31:0] exp_res, input logic [31:0] exp_cnt);
        drive0(1'b1, 1'b1, 5'd7, 2'd1, f3, off);
        step();
        check({tag, " result"}, 64'(bus0.ResultW), 64'(exp_res));
        check({tag, " regwrite"}, 64'(bus0.RegWriteW), 64'd1);
        check({tag, " instret"}, 64'(bus0.InstRetW), 64'(exp_cnt));
    endtask

    initial begin
        rst_n            = 1'b0;
        bus0.StallW      = 1'b0;
        bus0.FlushW      = 1'b0;
        bus0.SrcDataM    = {32'hFFFFF800, 32'h00001004, 32'h80FF7F01, 32'h12345678};
        drive0(1'b0, 1'b0, 5'd0, 2'd0, 3'b000, 2'd0);
        bus1.StallW      = 1'b0;
        bus1.FlushW      = 1'b0;
        bus1.ValidM      = 1'b0;
        bus1.RegWriteM   = 1'b0;
        bus1.RdM         = 5'd0;
        bus1.ResultSrcM  = 2'd0;
        bus1.SrcDataM    = {3{32'hFFFFFFFF}};
        bus1.LoadFunct3M = 3'b000;
        bus1.ByteOffsetM = 2'd0;

        #3;
        check("rst valid", 64'(bus0.ValidW), 64'd0);
        check("rst result", 64'(bus0.ResultW), 64'd0);
        check("rst instret", 64'(bus0.InstRetW), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU path
        drive0(1'b1, 1'b1, 5'd5, 2'd0, 3'b000, 2'd0);
        step();
        check("alu valid", 64'(bus0.ValidW), 64'd1);
        check("alu regwrite", 64'(bus0.RegWriteW), 64'd1);
        check("alu rd", 64'(bus0.RdW), 64'd5);
        check("alu result", 64'(bus0.ResultW), 64'h12345678);
        check("alu instret", 64'(bus0.InstRetW), 64'd1);

        // Load extension on src1 = 0x80FF7F01
        load0("lb1", 3'b000, 2'd1, 32'h0000007F, 32'd2);
        load0("lb2", 3'b000, 2'd2, 32'hFFFFFFFF, 32'd3);
        load0("lbu3", 3'b100, 2'd3, 32'h00000080, 32'd4);
        load0("lh2", 3'b001, 2'd2, 32'hFFFF80FF, 32'd5);
        load0("lhu0", 3'b101, 2'd0, 32'h00007F01, 32'd6);
        load0("lw0", 3'b010, 2'd0, 32'h80FF7F01, 32'd7);

        // Misaligned LW
        drive0(1'b1, 1'b1, 5'd3, 2'd1, 3'b010, 2'd2);
        step();
        check("mis result", 64'(bus0.ResultW), 64'd0);
        check("mis regwrite", 64'(bus0.RegWriteW), 64'd0);
        check("mis flag", 64'(bus0.MisalignW), 64'd1);
        check("mis instret", 64'(bus0.InstRetW), 64'd8);

        // Stall two cycles with a fresh ALU op pending
        bus0.StallW = 1'b1;
        drive0(1'b1, 1'b1, 5'd9, 2'd0, 3'b000, 2'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall rd", 64'(bus0.RdW), 64'd3);
            check("stall misalign", 64'(bus0.MisalignW), 64'd1);
            check("stall instret", 64'(bus0.InstRetW), 64'd8);
        end

        // Flush beats stall
        bus0.FlushW = 1'b1;
        step();
        check("flush valid", 64'(bus0.ValidW), 64'd0);
        check("flush regwrite", 64'(bus0.RegWriteW), 64'd0);
        check("flush misalign", 64'(bus0.MisalignW), 64'd0);
        check("flush instret", 64'(bus0.InstRetW), 64'd8);
        bus0.FlushW = 1'b0;
        bus0.StallW = 1'b0;

        // ValidM=0 bubble
        drive0(1'b0, 1'b1, 5'd4, 2'd0, 3'b000, 2'd0);
        step();
        check("bubble valid", 64'(bus0.ValidW), 64'd0);
        check("bubble instret", 64'(bus0.InstRetW), 64'd8);

        // rd = x0 never writes
        drive0(1'b1, 1'b1, 5'd0, 2'd0, 3'b000, 2'd0);
        step();
        check("x0 regwrite", 64'(bus0.RegWriteW), 64'd0);
        check("x0 valid", 64'(bus0.ValidW), 64'd1);
        check("x0 instret", 64'(bus0.InstRetW), 64'd9);

        // PC+4 and immediate sources; non-load funct3 must not flag misalign
        drive0(1'b1, 1'b1, 5'd1, 2'd2, 3'b010, 2'd1);
        step();
        check("pc4 result", 64'(bus0.ResultW), 64'h00001004);
        check("pc4 misalign", 64'(bus0.MisalignW), 64'd0);
        drive0(1'b1, 1'b1, 5'd2, 2'd3, 3'b000, 2'd0);
        step();
        check("imm result", 64'(bus0.ResultW), 64'hFFFFF800);
        check("imm instret", 64'(bus0.InstRetW), 64'd11);
        drive0(1'b0, 1'b0, 5'd0, 2'd0, 3'b000, 2'd0);

        // NUM_SRC=3: select 3 gives zero; then CNT_WIDTH=4 wrap
        check("w4 start", 64'(bus1.InstRetW), 64'd0);
        bus1.ValidM     = 1'b1;
        bus1.RegWriteM  = 1'b1;
        bus1.RdM        = 5'd4;
        bus1.ResultSrcM = 2'd3;
        step();
        check("badsel result", 64'(bus1.ResultW), 64'd0);
        check("badsel regwrite", 64'(bus1.RegWriteW), 64'd1);
        bus1.ResultSrcM = 2'd0;
        for (int i = 0; i < 14; i++) step();
        check("w4 fifteen", 64'(bus1.InstRetW), 64'd15);
        step();
        check("w4 wrap", 64'(bus1.InstRetW), 64'd0);
        bus1.ValidM = 1'b0;

        // Asynchronous reset mid-stream, between edges
        drive0(1'b1, 1'b1, 5'd6, 2'd0, 3'b000, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst valid", 64'(bus0.ValidW), 64'd0);
        check("arst regwrite", 64'(bus0.RegWriteW), 64'd0);
        check("arst rd", 64'(bus0.RdW), 64'd0);
        check("arst result", 64'(bus0.ResultW), 64'd0);
        check("arst misalign", 64'(bus0.MisalignW), 64'd0);
        check("arst instret", 64'(bus0.InstRetW), 64'd0);
        #2;
        rst_n = 1'b1;
        drive0(1'b1, 1'b1, 5'd9, 2'd0, 3'b000, 2'd0);
        step();
        check("post rst rd", 64'(bus0.RdW), 64'd9);
        check("post rst result", 64'(bus0.ResultW), 64'h12345678);
        check("post rst instret", 64'(bus0.InstRetW), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_result_stage.md
WB_RESULT_STAGE -- requirements
Module: wb_result_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, result/source width; legal values >= 32.
REQ-002 SHALL have parameter NUM_SRC, default 4, number of result sources (index 0 ALU, 1 load, 2 PC+4, 3 immediate).
REQ-003 SHALL have parameter LOAD_IDX, default 1, source index that receives load extension.
REQ-004 SHALL have parameter CNT_WIDTH, default 32, retire counter width.
REQ-005 SHALL derive SEL_WIDTH = max(1, $clog2(NUM_SRC)) internally.
REQ-006 clk  input  1  rising-edge clock, single clock domain.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 StallW  input  1  hold W register contents.
REQ-009 FlushW  input  1  insert bubble into W.
REQ-010 ValidM  input  1  M-stage instruction valid.
REQ-011 RegWriteM  input  1  M-stage instruction writes rd.
REQ-012 RdM  input  5  destination register.
REQ-013 ResultSrcM  input  SEL_WIDTH  source select.
REQ-014 SrcDataM  input  NUM_SRC*DATA_WIDTH  flattened sources, source i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 LoadFunct3M  input  3  load type (funct3).
REQ-016 ByteOffsetM  input  2  load address bits [1:0].
REQ-017 ValidW  output  1  W-stage valid.
REQ-018 RegWriteW  output  1  register-file write enable.
REQ-019 RdW  output  5  write address.
REQ-020 ResultW  output  DATA_WIDTH  write data.
REQ-021 MisalignW  output  1  W-stage load was misaligned.
REQ-022 InstRetW  output  CNT_WIDTH  retired-instruction count.

Function
REQ-023 Selection and extension SHALL be combinational on M inputs; all outputs SHALL be registered; latency exactly 1 cycle M->W.
REQ-024 ResultSrcM >= NUM_SRC SHALL select zero.
REQ-025 When ResultSrcM == LOAD_IDX, the word SHALL be extended per LoadFunct3M: 000 LB, sign-extended byte at ByteOffsetM; 001 LH, sign-extended half at offset {ByteOffsetM[1],0}; 010 LW, full low 32 bits; 100 LBU / 101 LHU, zero-extended equivalents; other codes pass source unchanged.
REQ-026 Extension above bit 31 SHALL replicate the sign (signed) or zero (unsigned) out to DATA_WIDTH.
REQ-027 Misalignment SHALL be LH/LHU with ByteOffsetM[0]=1, or LW with ByteOffsetM != 0; in that case ResultW SHALL be 0, RegWriteW 0, MisalignW 1.
REQ-028 RegWriteW SHALL be registered as RegWriteM & ValidM & (RdM != 0) & !misaligned; rd = x0 never writes.
REQ-029 StallW=1, FlushW=0: all W registers and InstRetW SHALL hold.
REQ-030 FlushW=1 SHALL take priority over StallW: next edge ValidW=0, RegWriteW=0, MisalignW=0; RdW and ResultW may load but are don't-care.
REQ-031 ValidM=0 (no stall/flush) SHALL load a bubble identical to REQ-030.
REQ-032 InstRetW SHALL increment by 1 on each edge where the W register loads with ValidM=1, FlushW=0, StallW=0, misaligned loads included.
REQ-033 InstRetW SHALL wrap from 2^CNT_WIDTH-1 to 0 with no flag.
REQ-034 RegWriteW and ResultW SHALL be stable the full cycle for register-file write on the next edge.

Reset
REQ-035 rst_n low SHALL immediately, independent of clk, force ValidW=0, RegWriteW=0, RdW=0, ResultW=0, MisalignW=0, InstRetW=0.
REQ-036 Reset asserted mid-stream SHALL discard the in-flight instruction; the first edge after deassertion SHALL load M inputs normally.

Verification
REQ-037 ALU path: ValidM=1, RegWriteM=1, RdM=5, ResultSrcM=0, src0=0x12345678 -> next cycle RegWriteW=1, RdW=5, ResultW=0x12345678, InstRetW=1.
REQ-038 Load extension: src1=0x80FF7F01; LB off 1 -> 0x0000007F; LB off 2 -> 0xFFFFFFFF; LBU off 3 -> 0x00000080; LH off 2 -> 0xFFFF80FF; LHU off 0 -> 0x00007F01.
REQ-039 Misalign: LW off 2, RdM=3 -> ResultW=0, RegWriteW=0, MisalignW=1, InstRetW increments.
REQ-040 Stall/flush: StallW=1 two cycles -> outputs and InstRetW frozen; FlushW=1 with StallW=1 -> ValidW=0, RegWriteW=0 next edge.
REQ-041 x0 and bad select: RdM=0, RegWriteM=1 -> RegWriteW=0; ResultSrcM=3 with NUM_SRC=3 -> ResultW=0.
REQ-042 Reset/wrap: CNT_WIDTH=4, 15 retires -> InstRetW=15, next retire -> 0; rst_n low between edges -> all outputs 0 without a clock edge.
